spi_master_tx: RTL and testbench



---
 rtl/spi_master_tx.sv | 125 ++++++++++++
 tb/tb_spi_master_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI Mode-0 master: one full-duplex 8-bit transfer per start request.
// Every non-idle state lasts HALF_DIV SCLK cycles; all outputs registered.
module spi_master_tx #(
    parameter int HALF_DIV = 2
) (
    input  logic       SCLK,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       CS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int PH_W = $clog2(HALF_DIV + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } state_t;

    state_t          r_state;
    logic [PH_W-1:0] r_phase;
    logic [2:0]      r_bit;
    logic [6:0]      r_tx_shift;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_data;
    logic            r_busy;
    logic            r_done;
    logic            r_cs;
    logic            r_sck;
    logic            r_mosi;
    logic            w_phase_end;

    assign w_phase_end = (r_phase == PH_LAST);

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign CS      = r_cs;
    assign SCK     = r_sck;
    assign MOSI    = r_mosi;

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_bit      <= 3'd0;
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Phase restarts on every state change, which happens only at phase end
            if (r_state != IDLE) begin
                r_phase <= w_phase_end ? '0 : r_phase + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx_shift <= tx_data[6:0];
                        r_mosi     <= tx_data[7];
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit      <= 3'd0;
                        r_phase    <= '0;
                        r_state    <= SETUP;
                    end
                end
                SETUP, SCK_LO: begin
                    if (w_phase_end) begin
                        r_sck      <= 1'b1;
                        r_rx_shift <= {r_rx_shift[6:0], MISO};
                        r_state    <= SCK_HI;
                    end
                end
                SCK_HI: begin
                    if (w_phase_end) begin
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state <= HOLD;
                        end else begin
                            r_mosi     <= r_tx_shift[6];
                            r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            r_bit      <= r_bit + 3'd1;
                            r_state    <= SCK_LO;
                        end
                    end
                end
                HOLD: begin
                    if (w_phase_end) begin
                        r_cs      <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx_shift;
                        r_done    <= 1'b1;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    // Guarantees a minimum CS-high time between transfers
                    if (w_phase_end) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx at HALF_DIV = 1, 2 and 255.
// Edge numbers count from the accepted start edge (edge 0).
module tb_spi_master_tx;

    logic SCLK = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 SCLK = ~SCLK;

    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic       miso2 = 1'b0;
    logic       busy2, done2, cs2, sck2, mosi2;
    logic [7:0] rx2;

    logic       start1 = 1'b0;
    logic [7:0] tx1 = 8'h00;
    wire        miso1;
    logic       busy1, done1, cs1, sck1, mosi1;
    logic [7:0] rx1;

    logic       start255 = 1'b0;
    logic [7:0] tx255 = 8'h00;
    logic       miso255 = 1'b0;
    logic       busy255, done255, cs255, sck255, mosi255;
    logic [7:0] rx255;

    assign miso1 = mosi1;

    spi_master_tx #(.HALF_DIV(2)) u_h2 (
        .SCLK(SCLK), .reset(reset), .start(start2), .tx_data(tx2),
        .busy(busy2), .done(done2), .rx_data(rx2), .CS(cs2),
        .SCK(sck2), .MOSI(mosi2), .MISO(miso2)
    );

    spi_master_tx #(.HALF_DIV(1)) u_h1 (
        .SCLK(SCLK), .reset(reset), .start(start1), .tx_data(tx1),
        .busy(busy1), .done(done1), .rx_data(rx1), .CS(cs1),
        .SCK(sck1), .MOSI(mosi1), .MISO(miso1)
    );

    spi_master_tx #(.HALF_DIV(255)) u_h255 (
        .SCLK(SCLK), .reset(reset), .start(start255), .tx_data(tx255),
        .busy(busy255), .done(done255), .rx_data(rx255), .CS(cs255),
        .SCK(sck255), .MOSI(mosi255), .MISO(miso255)
    );

    // Runs one H=2 transfer with a Mode-0 slave returning sb; measures only.
    task automatic run2(
        input  logic [7:0] tx,
        input  logic [7:0] sb,
        input  int         ncyc,
        input  int         pulse_e,
        input  int         rst_rise,
        output logic [7:0] mo,
        output int         rises,
        output int         dones,
        output int         done_e,
        output int         bfall_e,
        output int         cs_falls,
        output logic       rst_ok
    );
        int   idx;
        logic p_cs, p_sck, p_busy;
        mo = 8'h00; rises = 0; dones = 0; done_e = -1;
        bfall_e = -1; cs_falls = 0; rst_ok = 1'b0; idx = 7;
        p_cs = cs2; p_sck = sck2; p_busy = busy2;
        tx2 = tx; start2 = 1'b1; miso2 = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            @(posedge SCLK); #1;
            if (e == 0) begin start2 = 1'b0; tx2 = 8'hFF; end
            if (e == pulse_e - 1) begin start2 = 1'b1; tx2 = 8'h12; end
            if (e == pulse_e) start2 = 1'b0;
            if (p_cs && !cs2) begin
                cs_falls++; idx = 7; miso2 = sb[idx];
            end
            if (p_sck && !sck2 && idx > 0) begin
                idx--; miso2 = sb[idx];
            end
            if (done2) begin dones++; done_e = e; end
            if (p_busy && !busy2) bfall_e = e;
            if (sck2 && !p_sck) begin
                rises++; mo = {mo[6:0], mosi2};
                if (rises == rst_rise) begin
                    reset = 1'b1; #1;
                    rst_ok = cs2 && !sck2 && !busy2 && !done2;
                    break;
                end
            end
            p_cs = cs2; p_sck = sck2; p_busy = busy2;
        end
    endtask

    task automatic test_reset;
        int act;
        repeat (3) @(posedge SCLK);
        #1;
        checks++; if (cs2 !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b want=1", cs2); end
        checks++; if (sck2 !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b want=0", sck2); end
        checks++; if (mosi2 !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", mosi2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done2); end
        checks++; if (rx2 !== 8'h00) begin errors++; $display("FAIL reset_rx got=%h want=00", rx2); end
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge SCLK); #1;
            if (sck2 || !cs2 || busy2 || sck1 || sck255) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL idle_quiet active_cycles=%0d want=0", act); end
    endtask

    task automatic test_basic;
        logic [7:0] mo;
        int r, d, de, bf, cf;
        logic ok;
        run2(8'hA5, 8'h3C, 45, -1, 0, mo, r, d, de, bf, cf, ok);
        checks++; if (mo !== 8'hA5) begin errors++; $display("FAIL basic_mosi got=%h want=a5", mo); end
        checks++; if (rx2 !== 8'h3C) begin errors++; $display("FAIL basic_rx got=%h want=3c", rx2); end
        checks++; if (r !== 8) begin errors++; $display("FAIL basic_rises got=%0d want=8", r); end
        checks++; if (d !== 1 || de !== 34) begin errors++; $display("FAIL basic_done count=%0d edge=%0d want 1 at 34", d, de); end
        checks++; if (bf !== 36) begin errors++; $display("FAIL basic_busy_fall got=%0d want=36", bf); end
        checks++; if (cs2 !== 1'b1) begin errors++; $display("FAIL basic_cs_end got=%b want=1", cs2); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] expv [3];
        int de [3];
        int k, nd, cs_hi;
        logic p_busy, p_cs;
        expv[0] = 8'h00; expv[1] = 8'hFF; expv[2] = 8'h81;
        k = 0; nd = 0; cs_hi = 0;
        p_busy = busy1; p_cs = cs1;
        tx1 = 8'h00; start1 = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(posedge SCLK); #1;
            if (busy1 && !p_busy) begin
                k++;
                tx1 = (k == 1) ? 8'hFF : (k == 2) ? 8'h81 : 8'h00;
                if (k == 3) start1 = 1'b0;
            end
            if (done1) begin
                checks++;
                if (nd > 2) begin
                    errors++; $display("FAIL b2b_extra_done got=%0d want<=3", nd + 1);
                end else begin
                    if (rx1 !== expv[nd]) begin errors++; $display("FAIL b2b_rx%0d got=%h want=%h", nd, rx1, expv[nd]); end
                    if (nd > 0) begin
                        checks++;
                        if (e - de[nd-1] !== 19) begin errors++; $display("FAIL b2b_spacing%0d got=%0d want=19", nd, e - de[nd-1]); end
                    end
                    de[nd] = e;
                end
                nd++;
            end
            if (p_cs && !cs1) begin
                if (nd > 0) begin
                    checks++;
                    if (cs_hi < 1) begin errors++; $display("FAIL b2b_cs_gap got=%0d want>=1", cs_hi); end
                end
                cs_hi = 0;
            end
            if (cs1) cs_hi++;
            p_busy = busy1; p_cs = cs1;
        end
        start1 = 1'b0;
        checks++; if (nd !== 3 || k !== 3) begin errors++; $display("FAIL b2b_count dones=%0d starts=%0d want 3/3", nd, k); end
    endtask

    task automatic test_start_while_busy;
        logic [7:0] mo;
        int r, d, de, bf, cf;
        logic ok;
        run2(8'hC3, 8'h00, 60, 5, 0, mo, r, d, de, bf, cf, ok);
        checks++; if (mo !== 8'hC3) begin errors++; $display("FAIL swb_mosi got=%h want=c3", mo); end
        checks++; if (d !== 1) begin errors++; $display("FAIL swb_dones got=%0d want=1", d); end
        checks++; if (cf !== 1 || r !== 8) begin errors++; $display("FAIL swb_single cs_falls=%0d rises=%0d want 1/8", cf, r); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL swb_busy_end got=%b want=0", busy2); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] mo;
        int r, d, de, bf, cf, dr;
        logic ok;
        run2(8'h77, 8'h00, 60, -1, 3, mo, r, d, de, bf, cf, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_reset_outputs cs=%b sck=%b busy=%b want 1/0/0", cs2, sck2, busy2); end
        dr = d;
        repeat (2) begin
            @(posedge SCLK); #1;
            if (done2) dr++;
        end
        checks++; if (dr !== 0) begin errors++; $display("FAIL mid_reset_done got=%0d want=0", dr); end
        reset = 1'b0;
        run2(8'h5A, 8'hE7, 45, -1, 0, mo, r, d, de, bf, cf, ok);
        checks++; if (mo !== 8'h5A) begin errors++; $display("FAIL mid_after_mosi got=%h want=5a", mo); end
        checks++; if (rx2 !== 8'hE7) begin errors++; $display("FAIL mid_after_rx got=%h want=e7", rx2); end
        checks++; if (d !== 1 || de !== 34) begin errors++; $display("FAIL mid_after_done count=%0d edge=%0d want 1 at 34", d, de); end
    endtask

    task automatic test_divider_max;
        logic [7:0] sb, mo;
        int idx, cs_f, cs_r, last_t, ntr, bad, d;
        logic p_cs, p_sck;
        sb = 8'h69; mo = 8'h00; idx = 7;
        cs_f = -1; cs_r = -1; last_t = 0; ntr = 0; bad = 0; d = 0;
        p_cs = cs255; p_sck = sck255;
        tx255 = 8'h96; start255 = 1'b1;
        for (int e = 0; e < 4700; e++) begin
            @(posedge SCLK); #1;
            if (e == 0) begin start255 = 1'b0; tx255 = 8'h00; end
            if (p_cs && !cs255) begin cs_f = e; idx = 7; miso255 = sb[idx]; end
            if (!p_cs && cs255) cs_r = e;
            if (p_sck !== sck255) begin
                ntr++;
                if (e - last_t !== 255) bad++;
                last_t = e;
                if (sck255) mo = {mo[6:0], mosi255};
                else if (idx > 0) begin idx--; miso255 = sb[idx]; end
            end
            if (done255) d++;
            p_cs = cs255; p_sck = sck255;
        end
        checks++; if (cs_f !== 0 || cs_r - cs_f !== 4335) begin errors++; $display("FAIL h255_cs_low fall=%0d rise=%0d want 0/4335", cs_f, cs_r); end
        checks++; if (ntr !== 16 || bad !== 0) begin errors++; $display("FAIL h255_phases transitions=%0d bad=%0d want 16/0", ntr, bad); end
        checks++; if (mo !== 8'h96) begin errors++; $display("FAIL h255_mosi got=%h want=96", mo); end
        checks++; if (rx255 !== 8'h69 || d !== 1) begin errors++; $display("FAIL h255_rx got=%h dones=%0d want 69/1", rx255, d); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_start_while_busy;
        test_reset_mid;
        test_divider_max;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
